// File: rtl/coin_payout_pkg.sv
// coin_payout_pkg: shared state encodings, coin select encoding and coin values for coin_payout.
package coin_payout_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_EJECT  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef enum logic [1:0] {COIN_NONE, COIN_N, COIN_D, COIN_Q} coin_t;

    localparam int NICKEL_VAL  = 1;
    localparam int DIME_VAL    = 2;
    localparam int QUARTER_VAL = 5;

    function automatic int coin_val(coin_t c);
        return c == COIN_Q ? QUARTER_VAL : c == COIN_D ? DIME_VAL : c == COIN_N ? NICKEL_VAL : 0;
    endfunction

endpackage

// File: rtl/coin_payout_pick.sv
// coin_pick: combinational greedy coin selector.
// Ports: remain (unpaid nickels), inv_q/inv_d/inv_n (inventory counts) in;
//        coin (selected denomination, COIN_NONE if nothing fits), value (its nickel value) out.
module coin_pick
    import coin_payout_pkg::*;
#(
    parameter int AMT_W = 5,
    parameter int INV_W = 8
) (
    input  logic [AMT_W-1:0] remain,
    input  logic [INV_W-1:0] inv_q,
    input  logic [INV_W-1:0] inv_d,
    input  logic [INV_W-1:0] inv_n,
    output coin_t            coin,
    output logic [AMT_W-1:0] value
);

    always_comb begin
        coin  = (int'(remain) >= QUARTER_VAL && inv_q != '0) ? COIN_Q :
                (int'(remain) >= DIME_VAL    && inv_d != '0) ? COIN_D :
                (int'(remain) >= NICKEL_VAL  && inv_n != '0) ? COIN_N : COIN_NONE;
        value = AMT_W'(coin_val(coin));
    end

endmodule

// File: rtl/coin_payout.sv
// coin_payout: change-return engine paying a nickel-unit refund as quarter/dime/nickel eject pulses.
// Ports: clk, reset (async active-low); req_valid/req_amount/req_ready request handshake;
//        hop_ack per-coin hopper acknowledge; Q_out/D_out/N_out one-hot eject pulses;
//        load_en/load_sel/load_val inventory refill (IDLE only); done completion pulse;
//        short_out exact change impossible; remain unpaid nickels; fault ack timeout.
// Optional feature: define COIN_PAYOUT_TIMEOUT_EN to abort a coin after TIMEOUT_CYC
// WAIT_ACK cycles without hop_ack; otherwise fault stays 0 and WAIT_ACK waits forever.
module coin_payout
    import coin_payout_pkg::*;
#(
    parameter int AMT_W       = 5,
    parameter int INV_W       = 8,
    parameter int PULSE_CYC   = 2,
    parameter int INIT_Q      = 20,
    parameter int INIT_D      = 20,
    parameter int INIT_N      = 20,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             hop_ack,
    output logic             Q_out,
    output logic             D_out,
    output logic             N_out,
    input  logic             load_en,
    input  logic [1:0]       load_sel,
    input  logic [INV_W-1:0] load_val,
    output logic             done,
    output logic             short_out,
    output logic [AMT_W-1:0] remain,
    output logic             fault
);

    localparam int PW = PULSE_CYC > 1 ? $clog2(PULSE_CYC) : 1;

    logic [2:0]       state;
    logic [INV_W-1:0] inv_q, inv_d, inv_n;
    coin_t            coin, pick;
    logic [AMT_W-1:0] val, pick_val;
    logic [PW-1:0]    pcnt;

`ifdef COIN_PAYOUT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    coin_pick #(.AMT_W(AMT_W), .INV_W(INV_W)) u_pick (
        .remain(remain),
        .inv_q (inv_q),
        .inv_d (inv_d),
        .inv_n (inv_n),
        .coin  (pick),
        .value (pick_val)
    );

    // Outputs decode straight from state so an async reset drops any pulse at once.
    assign req_ready = state == S_IDLE;
    assign done      = state == S_DONE;
    assign Q_out     = state == S_EJECT && coin == COIN_Q;
    assign D_out     = state == S_EJECT && coin == COIN_D;
    assign N_out     = state == S_EJECT && coin == COIN_N;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            remain    <= '0;
            inv_q     <= INV_W'(INIT_Q);
            inv_d     <= INV_W'(INIT_D);
            inv_n     <= INV_W'(INIT_N);
            coin      <= COIN_NONE;
            val       <= '0;
            pcnt      <= '0;
            short_out <= 1'b0;
            fault     <= 1'b0;
`ifdef COIN_PAYOUT_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            // Refill lands on the accept edge too, so SELECT already sees it.
            if (state == S_IDLE && load_en) begin
                if (load_sel == 2'd0) inv_n <= load_val;
                if (load_sel == 2'd1) inv_d <= load_val;
                if (load_sel == 2'd2) inv_q <= load_val;
            end
            case (state)
                S_IDLE: if (req_valid) begin
                    remain    <= req_amount;
                    short_out <= 1'b0;
                    fault     <= 1'b0;
                    state     <= S_SELECT;
                end
                S_SELECT: if (pick == COIN_NONE) begin
                    short_out <= remain != '0;
                    state     <= S_DONE;
                end else begin
                    coin  <= pick;
                    val   <= pick_val;
                    pcnt  <= '0;
                    state <= S_EJECT;
`ifdef COIN_PAYOUT_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                S_EJECT: if (pcnt == PW'(PULSE_CYC - 1)) state <= S_WAIT;
                         else pcnt <= pcnt + 1'b1;
                S_WAIT: if (hop_ack) begin
                    remain <= remain - val;
                    if (coin == COIN_Q) inv_q <= inv_q - 1'b1;
                    if (coin == COIN_D) inv_d <= inv_d - 1'b1;
                    if (coin == COIN_N) inv_n <= inv_n - 1'b1;
                    state  <= S_SELECT;
                end
`ifdef COIN_PAYOUT_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    fault <= 1'b1;
                    state <= S_DONE;
                end else tcnt <= tcnt + 1'b1;
`endif
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_payout.sv
// tb_coin_payout: randomized self-checking bench for coin_payout against a greedy change model.
module tb_coin_payout;

    localparam int PULSE = 2;
    localparam int R     = 30;
    localparam int FINAL_IDX = 5 + R;

    logic       clk, reset, req_valid, req_ready, hop_ack;
    logic [4:0] req_amount, remain;
    logic       Q_out, D_out, N_out, load_en, done, short_out, fault;
    logic [1:0] load_sel;
    logic [7:0] load_val;

    coin_payout #(.PULSE_CYC(PULSE)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready), .hop_ack(hop_ack), .Q_out(Q_out), .D_out(D_out), .N_out(N_out),
        .load_en(load_en), .load_sel(load_sel), .load_val(load_val), .done(done),
        .short_out(short_out), .remain(remain), .fault(fault)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit drv_timeout = 0;

    // Inputs as the DUT saw them on the last rising edge.
    logic cap_valid, cap_ready, cap_ack, cap_ld;
    int   cap_amt, cap_sel, cap_val;
    always @(posedge clk) begin
        cap_valid <= req_valid;
        cap_ready <= req_ready;
        cap_ack   <= hop_ack;
        cap_ld    <= load_en;
        cap_amt   <= int'(req_amount);
        cap_sel   <= int'(load_sel);
        cap_val   <= int'(load_val);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chks(input string nm, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got \"%s\" want \"%s\" (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state: inventories indexed 0=N,1=D,2=Q.
    int    inv_m[3];
    byte   exp_q[$];
    string exp_seq, obs, lit;
    bit    exp_short, cur_short, busy, waiting, prev_any, prev_done, has;
    int    run_rem, since, width, idx = 0, last_val, a, ones, ls, lr;
    byte   cur, l, e;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_pulse", {Q_out, D_out, N_out}, 0);
            chk("rst_ready", req_ready, 1);
            chk("rst_remain", remain, 0);
            chk("rst_done", done, 0);
            chk("rst_short", short_out, 0);
            chk("rst_fault", fault, 0);
            inv_m = '{20, 20, 20};
            exp_q.delete();
            busy = 0; waiting = 0; run_rem = 0; cur_short = 0;
            prev_any = 0; prev_done = 0; since = 99;
        end else begin
            if (cap_ld && cap_ready && cap_sel < 3) inv_m[cap_sel] = cap_val;
            if (prev_done) busy = 0;
            if (cap_valid && cap_ready) begin
                a = cap_amt;
                exp_seq = "";
                exp_q.delete();
                for (int k = 0; k < 40; k++) begin
                    if (a >= 5 && inv_m[2] > 0) begin e = "Q"; a -= 5; inv_m[2]--; end
                    else if (a >= 2 && inv_m[1] > 0) begin e = "D"; a -= 2; inv_m[1]--; end
                    else if (a >= 1 && inv_m[0] > 0) begin e = "N"; a -= 1; inv_m[0]--; end
                    else break;
                    exp_q.push_back(e);
                    exp_seq = $sformatf("%s%c", exp_seq, e);
                end
                exp_short = a != 0;
                run_rem = cap_amt; busy = 1; waiting = 0; cur_short = 0; since = 0; obs = "";
            end else if (cap_ack && waiting) begin
                run_rem -= last_val;
                waiting = 0;
                since = 0;
            end else since++;
            ones = int'(Q_out) + int'(D_out) + int'(N_out);
            chk("onehot", ones <= 1, 1);
            l = Q_out ? "Q" : D_out ? "D" : "N";
            if (ones != 0 && !prev_any) begin
                chk("pulse_latency", since, 1);
                e = exp_q.size() != 0 ? exp_q.pop_front() : "-";
                chk("coin", l, e);
                obs = $sformatf("%s%c", obs, l);
                cur = l; width = 1;
                last_val = l == "Q" ? 5 : l == "D" ? 2 : 1;
            end else if (ones != 0) begin
                width++;
                chk("coin_steady", l, cur);
            end else if (prev_any) begin
                chk("pulse_width", width, PULSE);
                waiting = 1;
            end
            if (done) begin
                chk("done_busy", busy, 1);
                chk("done_latency", since, 1);
                chk("done_coins_left", exp_q.size(), 0);
                chks("coin_seq", obs, exp_seq);
                cur_short = exp_short;
                has = 1; lit = ""; ls = 0; lr = 0;
                case (idx)
                    0: lit = "QDN";
                    1: lit = "DDDN";
                    2: begin ls = 1; lr = 1; end
                    3: lit = "QN";
                    4: ;
                    FINAL_IDX: lit = "QDN";
                    default: has = 0;
                endcase
                if (has) begin
                    chks("lit_seq", obs, lit);
                    chk("lit_short", short_out, ls);
                    chk("lit_remain", remain, lr);
                end
                idx++;
            end
            chk("remain", remain, run_rem);
            chk("short", short_out, cur_short);
            chk("fault", fault, 0);
            chk("ready", req_ready, !busy);
            chk("driver_timeout", drv_timeout, 0);
            prev_any = ones != 0;
            prev_done = done;
        end
    end

    // Acks each coin dly cycles after its pulse ends; throws ack noise during pulses.
    task automatic serve(input int dly);
        int n = 0;
        bit seen = 0;
        while (!done && n < 2000) begin
            if (Q_out | D_out | N_out) begin
                seen = 1;
                hop_ack = $urandom_range(0, 3) == 0;
            end else if (seen) begin
                hop_ack = 0;
                repeat (dly) @(negedge clk);
                hop_ack = 1;
                @(negedge clk);
                hop_ack = 0;
                seen = 0;
            end else hop_ack = 0;
            @(negedge clk);
            n++;
        end
        if (n >= 2000) drv_timeout = 1;
    endtask

    task automatic do_load(input int sel, input int val);
        @(negedge clk);
        load_en = 1; load_sel = 2'(sel); load_val = 8'(val);
        @(negedge clk);
        load_en = 0;
    endtask

    task automatic do_req(input int amt, input int dly, input bit ld, input int sel, input int val);
        @(negedge clk);
        req_valid = 1; req_amount = 5'(amt);
        load_en = ld; load_sel = 2'(sel); load_val = 8'(val);
        @(negedge clk);
        req_valid = 0; load_en = 0;
        serve(dly);
        @(negedge clk);
    endtask

    int ld, sel, val, n;

    initial begin
        reset = 0; req_valid = 0; req_amount = 0; hop_ack = 0;
        load_en = 0; load_sel = 0; load_val = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        do_req(8, 0, 0, 0, 0);
        do_load(2, 0);
        do_req(7, 2, 0, 0, 0);
        do_load(0, 0);
        do_req(1, 0, 0, 0, 0);
        do_load(2, 20);
        do_load(0, 20);
        do_req(6, 10, 0, 0, 0);
        do_req(0, 0, 0, 0, 0);
        for (int r = 0; r < R; r++) begin
            ld  = $urandom_range(0, 2);
            sel = $urandom_range(0, 3);
            val = $urandom_range(0, 4) == 0 ? $urandom_range(10, 40) : $urandom_range(0, 3);
            if (ld == 1) do_load(sel, val);
            do_req($urandom_range(0, 31), $urandom_range(0, 3), ld == 2, sel, val);
        end
        do_load(0, 20);
        @(negedge clk);
        req_valid = 1; req_amount = 5'd31;
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (!(Q_out | D_out | N_out) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) drv_timeout = 1;
        @(posedge clk);
        #1 reset = 0; hop_ack = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        do_req(8, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
